// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int SIZE_WORD = 16;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the single memory port to fetch or data access, holding it for a fixed latency
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W      = SIZE_WORD,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_done,
  output logic [WORD_W-1:0] d_rdata,
  output logic              busy,
  output logic              readM,
  output logic              writeM,
  output logic [WORD_W-1:0] address,
  inout  logic [WORD_W-1:0] data
);
  arb_state_t        state;
  owner_t            owner;
  logic [3:0]        cnt;
  logic [WORD_W-1:0] wdata;
  // writeM is high exactly during a write ACCESS, so it doubles as the bus enable
  assign data = writeM ? wdata : 'z;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      owner    <= OWNER_IF;
      cnt      <= '0;
      wdata    <= '0;
      address  <= '0;
      readM    <= 1'b0;
      writeM   <= 1'b0;
      busy     <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        ARB_IDLE: if (d_req || if_req) begin
          owner   <= d_req ? OWNER_D : OWNER_IF;
          address <= d_req ? d_addr : if_addr;
          wdata   <= d_wdata;
          readM   <= !(d_req && d_we);
          writeM  <= d_req && d_we;
          cnt     <= 4'(MEM_LATENCY - 1);
          busy    <= 1'b1;
          state   <= ARB_ACCESS;
        end
        ARB_ACCESS: if (cnt == 4'd0) begin
          if (!writeM && owner == OWNER_D) d_rdata <= data;
          if (!writeM && owner == OWNER_IF) if_rdata <= data;
          readM   <= 1'b0;
          writeM  <= 1'b0;
          d_done  <= owner == OWNER_D;
          if_done <= owner == OWNER_IF;
          state   <= ARB_DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus multi-cycle sequences for the memory port arbiter
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int L = 2;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [W-1:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_val = 0;
  logic if_done, d_done, busy, readM, writeM;
  logic [W-1:0] if_rdata, d_rdata, address;
  wire  [W-1:0] data;
  assign data = writeM ? 'z : mem_val;
  mem_port_arbiter #(.WORD_W(W), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .busy(busy), .readM(readM), .writeM(writeM),
    .address(address), .data(data));
  logic req1 = 0, req15 = 0;
  logic done1, done15, dd1, dd15, busy1, busy15, rd1, rd15, wr1, wr15;
  logic [W-1:0] rdata1, rdata15, drd1, drd15, addr1, addr15;
  wire  [W-1:0] data1, data15;
  assign data1  = wr1  ? 'z : 16'h1111;
  assign data15 = wr15 ? 'z : 16'h2222;
  mem_port_arbiter #(.WORD_W(W), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .if_req(req1), .if_addr(16'h0100), .if_done(done1),
    .if_rdata(rdata1), .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(16'h0),
    .d_done(dd1), .d_rdata(drd1), .busy(busy1), .readM(rd1), .writeM(wr1),
    .address(addr1), .data(data1));
  mem_port_arbiter #(.WORD_W(W), .MEM_LATENCY(15)) dut15 (
    .clk(clk), .reset_n(reset_n), .if_req(req15), .if_addr(16'h0200), .if_done(done15),
    .if_rdata(rdata15), .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(16'h0),
    .d_done(dd15), .d_rdata(drd15), .busy(busy15), .readM(rd15), .writeM(wr15),
    .address(addr15), .data(data15));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    chk("strobe_excl", {readM & writeM, rd1 & wr1, rd15 & wr15}, 3'b000);
    chk("done_excl", {if_done & d_done, done1 & dd1, done15 & dd15}, 3'b000);
  end

  typedef struct {
    logic ir, dr, we;
    logic [W-1:0] ia, da, wd, mv, eir, edr;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int n, rc, wc;
    logic sif, sd;
    @(negedge clk);
    if_req = v.ir; d_req = v.dr; d_we = v.we;
    if_addr = v.ia; d_addr = v.da; d_wdata = v.wd; mem_val = v.mv;
    n = 0; rc = 0; wc = 0; sif = 0; sd = 0;
    while (!sif && !sd && n < 40) begin
      @(negedge clk);
      n++;
      if (readM) rc++;
      if (writeM) wc++;
      if (readM || writeM) chk("addr", address, v.dr ? v.da : v.ia);
      if (writeM) chk("bus_wdata", data, v.wd); else chk("bus_released", data, v.mv);
      sif = if_done; sd = d_done;
    end
    if_req = 0; d_req = 0;
    chk("latency", n, L + 1);
    chk("read_cycles", rc, v.we ? 0 : L);
    chk("write_cycles", wc, v.we ? L : 0);
    chk("done_owner", {sd, sif}, v.dr ? 2'b10 : 2'b01);
    chk("if_rdata", if_rdata, v.eir);
    chk("d_rdata", d_rdata, v.edr);
    @(negedge clk);
    chk("done_one_cycle", {d_done, if_done}, 2'b00);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    int n, rc;
    logic seen;
    vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h6A01, 16'h6A01, 16'h0000};
    vecs[1] = '{0, 1, 1, 16'h0000, 16'h0020, 16'hBEEF, 16'h1234, 16'h6A01, 16'h0000};
    vecs[2] = '{0, 1, 0, 16'h0000, 16'h0030, 16'h0000, 16'hC0DE, 16'h6A01, 16'hC0DE};
    vecs[3] = '{1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'hC0DE};
    vecs[4] = '{0, 1, 1, 16'h0000, 16'h0000, 16'h5555, 16'h9999, 16'h0001, 16'hC0DE};
    vecs[5] = '{1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hC0DE};
    repeat (2) @(negedge clk);
    chk("rst_strobes", {readM, writeM, busy, if_done, d_done}, 5'b0);
    chk("rst_address", address, 16'h0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
    chk("rst_bus", data, mem_val);
    reset_n = 1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    // contention: data wins, fetch follows L+2 cycles after d_done
    @(negedge clk);
    if_req = 1; if_addr = 16'h0044; d_req = 1; d_we = 0; d_addr = 16'h0040; mem_val = 16'hAAAA;
    n = 0;
    while (!d_done && !if_done && n < 40) begin
      @(negedge clk);
      n++;
      if (readM) chk("cont_addr_d", address, 16'h0040);
    end
    chk("cont_first", {d_done, if_done}, 2'b10);
    chk("cont_d_rdata", d_rdata, 16'hAAAA);
    d_req = 0; mem_val = 16'hBBBB;
    n = 0;
    while (!if_done && n < 40) begin
      @(negedge clk);
      n++;
      if (readM) chk("cont_addr_if", address, 16'h0044);
    end
    if_req = 0;
    chk("cont_gap", n, L + 2);
    chk("cont_if_rdata", if_rdata, 16'hBBBB);
    chk("cont_d_kept", d_rdata, 16'hAAAA);
    @(negedge clk);
    // input churn after grant
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("churn_granted", writeM, 1'b1);
    d_addr = 16'hFFFF; d_wdata = 16'h0000; d_we = 0;
    n = 0;
    while (!d_done && n < 40) begin
      if (writeM) begin
        chk("churn_addr", address, 16'h0020);
        chk("churn_data", data, 16'hBEEF);
      end
      @(negedge clk);
      n++;
    end
    d_req = 0;
    chk("churn_done", d_done, 1'b1);
    chk("churn_d_rdata", d_rdata, 16'hAAAA);
    @(negedge clk);
    // request dropped mid-access still completes
    @(negedge clk);
    if_req = 1; if_addr = 16'h0050; mem_val = 16'h7777;
    @(negedge clk);
    if_req = 0;
    n = 0;
    while (!if_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drop_done", if_done, 1'b1);
    chk("drop_rdata", if_rdata, 16'h7777);
    repeat (2) @(negedge clk);
    chk("drop_no_regrant", {busy, readM}, 2'b00);
    // latency 1 and 15 builds
    req1 = 1; n = 0; rc = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rd1) rc++;
      seen = done1;
    end
    req1 = 0;
    chk("l1_strobe", rc, 1);
    chk("l1_latency", n, 2);
    chk("l1_rdata", rdata1, 16'h1111);
    req15 = 1; n = 0; rc = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rd15) begin
        rc++;
        chk("l15_addr", addr15, 16'h0200);
      end
      seen = done15;
    end
    req15 = 0;
    chk("l15_strobe", rc, 15);
    chk("l15_latency", n, 16);
    chk("l15_rdata", rdata15, 16'h2222);
    @(negedge clk);
    // asynchronous reset in the middle of an access
    @(negedge clk);
    if_req = 1; if_addr = 16'h0060;
    @(negedge clk);
    chk("arst_pre", readM, 1'b1);
    if_req = 0;
    reset_n = 0;
    #1;
    chk("arst_strobes", {readM, writeM, busy}, 3'b000);
    chk("arst_address", address, 16'h0);
    chk("arst_bus", data, mem_val);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | if_done | d_done;
    end
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | if_done | d_done;
    end
    chk("arst_no_done", seen, 1'b0);
    chk("arst_rdata", if_rdata, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
